// File: rtl/mac_tx_framer.sv
// mac_tx_framer: store-and-forward Ethernet transmit framer onto 8-bit GMII.
// Define MAC_TX_PAD_EN to zero-pad payloads shorter than 46 bytes (pad is covered by the FCS).
module mac_tx_framer #(
  parameter logic [47:0] P_SRC_MAC    = 48'h00_0A_35_01_FE_C0,
  parameter int          P_BUF_DEPTH  = 4096,
  parameter int          P_INFO_DEPTH = 4,
  parameter int          P_IFG_LEN    = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  input  logic [15:0] i_len,
  input  logic [15:0] i_type,
  input  logic [47:0] i_dst_mac,
  output logic [7:0]  o_gmii_txd,
  output logic        o_gmii_tx_en,
  output logic        o_overflow,
  output logic        o_len_err
);
  localparam int LP_AW = $clog2(P_BUF_DEPTH);
  localparam int LP_IW = $clog2(P_INFO_DEPTH);
  localparam logic [LP_AW:0] LP_BUF_FULL  = (LP_AW+1)'(P_BUF_DEPTH);
  localparam logic [LP_IW:0] LP_INFO_FULL = (LP_IW+1)'(P_INFO_DEPTH);
  localparam logic [15:0]    LP_IFG_LAST  = 16'(P_IFG_LEN - 1);

`ifdef MAC_TX_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG} t_state;
`else
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_FCS, S_IFG} t_state;
`endif

  function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ data[i]) ? 32'hEDB8_8320 : 32'h0);
    end
    return c;
  endfunction

  logic [7:0]     r_buf [P_BUF_DEPTH];
  logic [79:0]    r_info [P_INFO_DEPTH];
  logic [7:0]     r_rdata;

  logic           r_in_frame, r_drop, r_overflow, r_len_err;
  logic [15:0]    r_cnt, r_len, r_type;
  logic [47:0]    r_dst;
  logic [LP_AW:0] r_wr_ptr, r_start_ptr, r_rd_ptr;
  logic [LP_IW-1:0] r_info_wr, r_info_rd;
  logic [LP_IW:0] r_info_cnt;

  t_state         r_state, w_state_next;
  logic [15:0]    r_cnt_tx, w_cnt_tx_next;
  logic [31:0]    r_crc, w_crc_next;
  logic [7:0]     r_txd, w_txd_next;
  logic           r_tx_en, w_tx_en_next;
  logic [47:0]    r_cur_dst;
  logic [15:0]    r_cur_type, r_cur_len;

  logic           w_first, w_dropping, w_buf_full, w_info_full;
  logic           w_wr_en, w_push, w_drop_now, w_pop, w_rd_en;
  logic [15:0]    w_cnt_cur, w_len_cur, w_type_cur;
  logic [47:0]    w_dst_cur;
  logic [LP_AW:0] w_start_ptr;
  logic [111:0]   w_hdr;
  logic [3:0]     w_hdr_idx;
  logic [7:0]     w_hdr_byte, w_fcs_byte;
  logic [31:0]    w_crc_inv;

  // Ingress: a frame that hits a full buffer or full descriptor FIFO is discarded whole.
  assign w_first     = i_valid && !r_in_frame;
  assign w_cnt_cur   = w_first ? 16'd1 : r_cnt + 16'd1;
  assign w_len_cur   = w_first ? i_len : r_len;
  assign w_type_cur  = w_first ? i_type : r_type;
  assign w_dst_cur   = w_first ? i_dst_mac : r_dst;
  assign w_start_ptr = w_first ? r_wr_ptr : r_start_ptr;
  assign w_dropping  = r_drop && !w_first;
  assign w_buf_full  = (r_wr_ptr - r_rd_ptr) == LP_BUF_FULL;
  assign w_info_full = r_info_cnt == LP_INFO_FULL;
  assign w_wr_en     = i_valid && !w_dropping && !w_buf_full;
  assign w_drop_now  = i_valid && !w_dropping && (w_buf_full || (i_last && w_info_full));
  assign w_push      = i_valid && i_last && !w_dropping && !w_buf_full && !w_info_full;

  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_buf[r_wr_ptr[LP_AW-1:0]] <= i_data;
    if (w_rd_en) r_rdata <= r_buf[r_rd_ptr[LP_AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_info[r_info_wr] <= {w_dst_cur, w_type_cur, w_cnt_cur};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_in_frame  <= 1'b0;
      r_drop      <= 1'b0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_type      <= '0;
      r_dst       <= '0;
      r_wr_ptr    <= '0;
      r_start_ptr <= '0;
      r_overflow  <= 1'b0;
      r_len_err   <= 1'b0;
      r_info_wr   <= '0;
    end else begin
      r_len_err <= 1'b0;
      if (i_valid) begin
        r_in_frame  <= !i_last;
        r_cnt       <= w_cnt_cur;
        r_len       <= w_len_cur;
        r_type      <= w_type_cur;
        r_dst       <= w_dst_cur;
        r_start_ptr <= w_start_ptr;
        r_drop      <= w_dropping || w_drop_now;
        r_len_err   <= i_last && (w_cnt_cur != w_len_cur);
        if (w_drop_now) begin
          r_overflow <= 1'b1;
          r_wr_ptr   <= w_start_ptr;
        end else if (w_wr_en) begin
          r_wr_ptr <= r_wr_ptr + (LP_AW+1)'(1);
        end
        if (w_push) r_info_wr <= r_info_wr + LP_IW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_info_cnt <= '0;
    end else if (w_push && !w_pop) begin
      r_info_cnt <= r_info_cnt + (LP_IW+1)'(1);
    end else if (w_pop && !w_push) begin
      r_info_cnt <= r_info_cnt - (LP_IW+1)'(1);
    end
  end

  // Egress byte sources
  assign w_hdr      = {r_cur_dst, P_SRC_MAC, r_cur_type};
  assign w_hdr_idx  = 4'd13 - r_cnt_tx[3:0];
  assign w_hdr_byte = w_hdr[{w_hdr_idx, 3'b000} +: 8];
  assign w_crc_inv  = ~r_crc;
  assign w_fcs_byte = w_crc_inv[{r_cnt_tx[1:0], 3'b000} +: 8];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt_tx   <= '0;
      r_crc      <= 32'hFFFF_FFFF;
      r_txd      <= '0;
      r_tx_en    <= 1'b0;
      r_rd_ptr   <= '0;
      r_info_rd  <= '0;
      r_cur_dst  <= '0;
      r_cur_type <= '0;
      r_cur_len  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt_tx <= w_cnt_tx_next;
      r_crc    <= w_crc_next;
      r_txd    <= w_txd_next;
      r_tx_en  <= w_tx_en_next;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + (LP_AW+1)'(1);
      if (w_pop) begin
        {r_cur_dst, r_cur_type, r_cur_len} <= r_info[r_info_rd];
        r_info_rd <= r_info_rd + LP_IW'(1);
      end
    end
  end

  // Outputs are computed one step ahead so the first preamble byte leaves on the pop cycle.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_tx_next = r_cnt_tx + 16'd1;
    w_crc_next    = r_crc;
    w_txd_next    = 8'h00;
    w_tx_en_next  = 1'b0;
    w_pop         = 1'b0;
    w_rd_en       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_tx_next = 16'd0;
        if (r_info_cnt != '0) begin
          w_pop         = 1'b1;
          w_txd_next    = 8'h55;
          w_tx_en_next  = 1'b1;
          w_state_next  = S_PRE;
          w_cnt_tx_next = 16'd1;
        end
      end
      S_PRE: begin
        w_txd_next   = 8'h55;
        w_tx_en_next = 1'b1;
        if (r_cnt_tx == 16'd6) w_state_next = S_SFD;
      end
      S_SFD: begin
        w_txd_next    = 8'hD5;
        w_tx_en_next  = 1'b1;
        w_crc_next    = 32'hFFFF_FFFF;
        w_state_next  = S_HDR;
        w_cnt_tx_next = 16'd0;
      end
      S_HDR: begin
        w_txd_next   = w_hdr_byte;
        w_tx_en_next = 1'b1;
        w_crc_next   = f_crc_byte(r_crc, w_hdr_byte);
        if (r_cnt_tx == 16'd13) begin
          w_rd_en       = 1'b1;
          w_state_next  = S_PAY;
          w_cnt_tx_next = 16'd0;
        end
      end
      S_PAY: begin
        w_txd_next   = r_rdata;
        w_tx_en_next = 1'b1;
        w_crc_next   = f_crc_byte(r_crc, r_rdata);
        if (r_cnt_tx == r_cur_len - 16'd1) begin
          w_state_next  = S_FCS;
          w_cnt_tx_next = 16'd0;
`ifdef MAC_TX_PAD_EN
          if (r_cur_len < 16'd46) begin
            w_state_next  = S_PAD;
            w_cnt_tx_next = r_cur_len;
          end
`endif
        end else begin
          w_rd_en = 1'b1;
        end
      end
`ifdef MAC_TX_PAD_EN
      S_PAD: begin
        w_tx_en_next = 1'b1;
        w_crc_next   = f_crc_byte(r_crc, 8'h00);
        if (r_cnt_tx == 16'd45) begin
          w_state_next  = S_FCS;
          w_cnt_tx_next = 16'd0;
        end
      end
`endif
      S_FCS: begin
        w_txd_next   = w_fcs_byte;
        w_tx_en_next = 1'b1;
        if (r_cnt_tx == 16'd3) begin
          w_state_next  = S_IFG;
          w_cnt_tx_next = 16'd0;
        end
      end
      S_IFG: begin
        if (r_cnt_tx == LP_IFG_LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_gmii_txd   = r_txd;
  assign o_gmii_tx_en = r_tx_en;
  assign o_overflow   = r_overflow;
  assign o_len_err    = r_len_err;
endmodule

// File: tb/tb_mac_tx_framer.sv
// tb_mac_tx_framer: directed frames into mac_tx_framer; captured GMII frames are checked
// against a byte-level model including a software CRC32.
module tb_mac_tx_framer;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic [15:0] i_len = '0;
  logic [15:0] i_type = '0;
  logic [47:0] i_dst_mac = '0;
  logic [7:0]  o_gmii_txd;
  logic        o_gmii_tx_en;
  logic        o_overflow;
  logic        o_len_err;

  localparam logic [47:0] SRC_MAC = 48'h00_0A_35_01_FE_C0;

  mac_tx_framer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
    .i_len(i_len), .i_type(i_type), .i_dst_mac(i_dst_mac),
    .o_gmii_txd(o_gmii_txd), .o_gmii_tx_en(o_gmii_tx_en),
    .o_overflow(o_overflow), .o_len_err(o_len_err)
  );

  always #4 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // GMII capture: flat byte store plus per-frame offset, length, start cycle and idle gap.
  logic [7:0] rx_bytes[$];
  int rx_off[$], rx_lens[$], rx_start[$], rx_gap[$];
  int cur_len = 0, gap = 0, bad_idle = 0;
  bit in_frame = 0;

  always @(negedge i_clk) begin
    if (i_rst) begin
      if (in_frame) begin
        void'(rx_off.pop_back());
        void'(rx_start.pop_back());
        void'(rx_gap.pop_back());
      end
      in_frame = 0;
      cur_len = 0;
      gap = 0;
    end else if (o_gmii_tx_en) begin
      if (!in_frame) begin
        rx_off.push_back(rx_bytes.size());
        rx_start.push_back(cyc);
        rx_gap.push_back(gap);
        in_frame = 1;
        cur_len = 0;
      end
      rx_bytes.push_back(o_gmii_txd);
      cur_len++;
    end else begin
      if (in_frame) begin
        rx_lens.push_back(cur_len);
        in_frame = 0;
        gap = 0;
      end
      gap++;
      if (o_gmii_txd != 8'h00) bad_idle++;
    end
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic send_frame(input int n, input logic [15:0] len_f, input logic [15:0] typ,
                            input logic [47:0] dst, input logic [7:0] seed,
                            output int last_cyc, output logic lerr0, output logic lerr1);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_data  = seed + 8'(i);
      i_last  = (i == n - 1);
      if (i == 0) begin
        i_len = len_f; i_type = typ; i_dst_mac = dst;
      end else begin
        i_len = 16'hDEAD; i_type = 16'hBEEF; i_dst_mac = 48'h1234_5678_9ABC;
      end
      last_cyc = cyc;
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    lerr0 = o_len_err;
    @(negedge i_clk);
    lerr1 = o_len_err;
  endtask

  task automatic verify_frame(input string tag, input int idx, input logic [47:0] dst,
                              input logic [15:0] typ, input int n, input logic [7:0] seed);
    logic [7:0] exp_q[$];
    logic [111:0] hdr;
    logic [7:0] b;
    logic [31:0] crc, exp_fcs, got_fcs;
    int waited, nbad, off, plen, last;
    waited = 0;
    while (rx_lens.size() <= idx && waited < 20000) begin
      @(negedge i_clk);
      waited++;
    end
    if (rx_lens.size() <= idx) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    crc = 32'hFFFF_FFFF;
    hdr = {dst, SRC_MAC, typ};
    for (int i = 0; i < 14; i++) begin
      b = hdr[111 - 8*i -: 8];
      exp_q.push_back(b);
      crc = crc_upd(crc, b);
    end
    for (int i = 0; i < n; i++) begin
      b = seed + 8'(i);
      exp_q.push_back(b);
      crc = crc_upd(crc, b);
    end
    plen = n;
`ifdef MAC_TX_PAD_EN
    while (plen < 46) begin
      exp_q.push_back(8'h00);
      crc = crc_upd(crc, 8'h00);
      plen++;
    end
`endif
    exp_fcs = ~crc;
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_fcs[8*i +: 8]);
    chk({tag, "_len"}, 64'(rx_lens[idx]), 64'(exp_q.size()));
    off = rx_off[idx];
    nbad = 0;
    for (int i = 0; i < exp_q.size() && i < rx_lens[idx]; i++)
      if (rx_bytes[off + i] !== exp_q[i]) nbad++;
    chk({tag, "_bytes"}, 64'(nbad), 64'd0);
    last = off + rx_lens[idx] - 4;
    got_fcs = {rx_bytes[last + 3], rx_bytes[last + 2], rx_bytes[last + 1], rx_bytes[last]};
    chk({tag, "_fcs"}, 64'(got_fcs), 64'(exp_fcs));
    $display("frame %s: payload=%0d tx_en_cycles=%0d fcs=%08h", tag, n, rx_lens[idx], got_fcs);
  endtask

  int lc, base, waited;
  logic e0, e1;

  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_txd", 64'(o_gmii_txd), 64'd0);
    chk("rst_tx_en", 64'(o_gmii_tx_en), 64'd0);
    chk("rst_overflow", 64'(o_overflow), 64'd0);
    chk("rst_len_err", 64'(o_len_err), 64'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // 1: short ARP frame, broadcast destination; latency from i_last to first preamble byte
    send_frame(28, 16'd28, 16'h0806, 48'hFFFF_FFFF_FFFF, 8'h10, lc, e0, e1);
    chk("t1_len_err", 64'(e0), 64'd0);
    verify_frame("t1", 0, 48'hFFFF_FFFF_FFFF, 16'h0806, 28, 8'h10);
`ifdef MAC_TX_PAD_EN
    if (rx_lens.size() > 0) chk("t1_tx_en_cycles", 64'(rx_lens[0]), 64'd72);
`else
    if (rx_lens.size() > 0) chk("t1_tx_en_cycles", 64'(rx_lens[0]), 64'd54);
`endif
    if (rx_start.size() > 0) chk("t1_latency", 64'(rx_start[0] - lc), 64'd2);

    // 2: 100-byte IP frame, never padded
    send_frame(100, 16'd100, 16'h0800, 48'h0011_2233_4455, 8'hA0, lc, e0, e1);
    verify_frame("t2", 1, 48'h0011_2233_4455, 16'h0800, 100, 8'hA0);
    if (rx_lens.size() > 1) chk("t2_tx_en_cycles", 64'(rx_lens[1]), 64'd126);

    // 3: second frame arrives while the first is on the wire; back-to-back gap is the IFG
    send_frame(50, 16'd50, 16'h0800, 48'h0A0B_0C0D_0E0F, 8'h03, lc, e0, e1);
    repeat (8) @(negedge i_clk);
    send_frame(20, 16'd20, 16'h0800, 48'h0A0B_0C0D_0E10, 8'h07, lc, e0, e1);
    verify_frame("t3a", 2, 48'h0A0B_0C0D_0E0F, 16'h0800, 50, 8'h03);
    verify_frame("t3b", 3, 48'h0A0B_0C0D_0E10, 16'h0800, 20, 8'h07);
    if (rx_gap.size() > 3) chk("t3_ifg", 64'(rx_gap[3]), 64'd12);

    // 4: declared length 64, only 60 bytes delivered
    send_frame(60, 16'd64, 16'h0800, 48'h0200_0000_0001, 8'h55, lc, e0, e1);
    chk("t4_len_err_pulse", 64'(e0), 64'd1);
    chk("t4_len_err_clear", 64'(e1), 64'd0);
    verify_frame("t4", 4, 48'h0200_0000_0001, 16'h0800, 60, 8'h55);

    // 5: one frame larger than the buffer is dropped; the next one still goes out
    repeat (20) @(negedge i_clk);
    base = rx_off.size();
    send_frame(4097, 16'd4097, 16'h0800, 48'h0200_0000_0002, 8'h01, lc, e0, e1);
    repeat (60) @(negedge i_clk);
    chk("t5_overflow", 64'(o_overflow), 64'd1);
    chk("t5_no_frame", 64'(rx_off.size()), 64'(base));
    send_frame(30, 16'd30, 16'h0800, 48'h0200_0000_0003, 8'h40, lc, e0, e1);
    verify_frame("t5", base, 48'h0200_0000_0003, 16'h0800, 30, 8'h40);
    chk("t5_overflow_sticky", 64'(o_overflow), 64'd1);

    // 6: reset in the middle of the payload
    repeat (20) @(negedge i_clk);
    send_frame(100, 16'd100, 16'h0800, 48'h0200_0000_0004, 8'h77, lc, e0, e1);
    waited = 0;
    while (!(in_frame && cur_len >= 40) && waited < 2000) begin
      @(negedge i_clk);
      waited++;
    end
    chk("t6_reached_pay", 64'(cur_len >= 40), 64'd1);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("t6_rst_tx_en", 64'(o_gmii_tx_en), 64'd0);
    chk("t6_rst_txd", 64'(o_gmii_txd), 64'd0);
    chk("t6_rst_overflow", 64'(o_overflow), 64'd0);
    chk("t6_rst_len_err", 64'(o_len_err), 64'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    base = rx_lens.size();
    send_frame(40, 16'd40, 16'h86DD, 48'h0200_0000_0005, 8'h22, lc, e0, e1);
    verify_frame("t6", base, 48'h0200_0000_0005, 16'h86DD, 40, 8'h22);
    if (rx_start.size() > base) chk("t6_latency", 64'(rx_start[base] - lc), 64'd2);

    chk("idle_txd_zero", 64'(bad_idle), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
